// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle MIPS datapath
//
// Purpose:
//   Sequences fetch, decode, execute, memory access and writeback over
//   several clocks. Control outputs are Moore-decoded from the current state.
//   The only exception is the FETCH-state PC/IR load, which is qualified by
//   memReady. Every memory state waits on memReady, and a stall counter
//   bounds that wait.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode              instruction [31:26] from the instruction register
//   functionField       instruction [5:0] from the instruction register
//   zero                ALU zero flag (the branch gate lives in the datapath)
//   memReady            memory finished the current access this cycle
//   PCWrite/PCWriteCond unconditional / zero-gated PC load
//   IorD                memory address select (0 PC, 1 ALUOut)
//   MemRead/MemWrite    memory requests
//   IRWrite             instruction register load
//   MemtoReg/RegDst     writeback data / destination select
//   RegWrite            register file write enable
//   AluSrcA/AluSrcB     ALU operand selects
//   AluOp               to AluControl (00 add, 01 sub, 10 funct)
//   PCSource            PC source (00 ALU, 01 ALUOut, 10 jump target)
//   illegalOp           one-cycle pulse in DECODE on an unsupported opcode
//   memTimeout          sticky memory-wait timeout, cleared only by reset

module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int STATE_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] functionField,
  input  logic       zero,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PCSource,
  output logic       illegalOp,
  output logic       memTimeout
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEM_ADDR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM_READ  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEM_WB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEM_WRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECUTE   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_R_WB      = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JUMP      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_ADDI_EX   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_ADDI_WB   = STATE_W'(11);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;

  logic stall;
  logic timeout_hit;
  logic op_legal;

  // The zero flag gates PCWriteCond inside the datapath; the FSM itself
  // never branches on it.
  logic unused_zero;
  assign unused_zero = zero;

  assign op_legal = (opcode == OP_R)  || (opcode == OP_LW)  ||
                    (opcode == OP_SW) || (opcode == OP_BEQ) ||
                    (opcode == OP_J)  || (opcode == OP_ADDI);

  // A stall is any cycle in a memory state that memory did not complete.
  assign stall = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                  (state_q == S_MEM_WRITE)) && !memReady;

  // This stall brings the counter to MEM_WAIT_MAX (or it is already
  // saturated there).
  assign timeout_hit = stall && (wait_cnt_q >= WAIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEM_READ;
        end else if (opcode == OP_SW) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_READ:  state_d = memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = memReady ? S_FETCH : S_MEM_WRITE;
      // An all-zero funct is a nop: it skips the writeback.
      S_EXECUTE:   state_d = (functionField == 6'b000000) ? S_FETCH : S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase

    // A timed-out wait abandons the access and restarts at fetch.
    if (timeout_hit) begin
      state_d = S_FETCH;
    end
  end

  // Wait counter and sticky timeout flag
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q | timeout_hit;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (stall && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Output decode. Everything is forced low while reset is asserted.
  // Without that, the FETCH reset state would drive MemRead during reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluOp       = 2'b00;
    PCSource    = 2'b00;
    illegalOp   = 1'b0;
    memTimeout  = mem_timeout_q;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          AluSrcB = 2'b01;
          PCWrite = memReady;
          IRWrite = memReady;
        end
        S_DECODE: begin
          AluSrcB   = 2'b11;
          illegalOp = !op_legal;
        end
        S_MEM_ADDR: begin
          AluSrcA = 1'b1;
          AluSrcB = 2'b10;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXECUTE: begin
          AluSrcA = 1'b1;
          AluOp   = 2'b10;
        end
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          AluSrcA     = 1'b1;
          AluOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDI_EX: begin
          AluSrcA = 1'b1;
          AluSrcB = 2'b10;
        end
        S_ADDI_WB: begin
          RegWrite = 1'b1;
        end
        default: begin
          PCWrite = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] functionField;
  logic       zero;
  logic       memReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, AluSrcA;
  logic [1:0] AluSrcB, AluOp, PCSource;
  logic       illegalOp, memTimeout;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_MAX(15), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .functionField(functionField),
    .zero(zero), .memReady(memReady), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSource(PCSource),
    .illegalOp(illegalOp), .memTimeout(memTimeout)
  );

  logic [16:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp,
                PCSource, illegalOp};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [16:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [16:0] pk(
      input logic pcw, pcwc, iord, mr, mw, irw, mtr, rd, rw, asa,
      input logic [1:0] asb, aop, pcs, input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, mtr, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected per-state control vectors, written directly from the state table
  logic [16:0] E_F1, E_F0, E_DEC, E_DILL, E_MADDR, E_MRD, E_MWB, E_MWR;
  logic [16:0] E_EXE, E_RWB, E_BR, E_JMP, E_AEX, E_AWB;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  task automatic add(input logic [5:0] op, input logic [5:0] fn,
                     input logic [16:0] exp, input string nm);
    vec_t v;
    v.op = op; v.fn = fn; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  // One clock: drive memReady, sample at the falling edge, then step past the rising edge
  task automatic step(input logic mr, input logic [16:0] exp, input string nm);
    memReady = mr;
    @(negedge clk);
    check(nm, 32'(obs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  function automatic bit supported(input logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == JMP || op == ADDI;
  endfunction

  initial begin
    E_F1    = pk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    E_F0    = pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    E_DEC   = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    E_DILL  = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    E_MADDR = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    E_MRD   = pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    E_MWB   = pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    E_MWR   = pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    E_EXE   = pk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    E_RWB   = pk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    E_BR    = pk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    E_JMP   = pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
    E_AEX   = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    E_AWB   = pk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);

    add(LW, 6'h00, E_F1, "lw_fetch");   add(LW, 6'h00, E_DEC, "lw_dec");
    add(LW, 6'h00, E_MADDR, "lw_addr"); add(LW, 6'h00, E_MRD, "lw_read");
    add(LW, 6'h00, E_MWB, "lw_wb");
    add(RT, 6'h20, E_F1, "add_fetch");  add(RT, 6'h20, E_DEC, "add_dec");
    add(RT, 6'h20, E_EXE, "add_exe");   add(RT, 6'h20, E_RWB, "add_wb");
    add(RT, 6'h00, E_F1, "nop_fetch");  add(RT, 6'h00, E_DEC, "nop_dec");
    add(RT, 6'h00, E_EXE, "nop_exe");
    add(6'h3f, 6'h00, E_F1, "ill_fetch"); add(6'h3f, 6'h00, E_DILL, "ill_dec");
    add(BEQ, 6'h00, E_F1, "beq_fetch"); add(BEQ, 6'h00, E_DEC, "beq_dec");
    add(BEQ, 6'h00, E_BR, "beq_br");
    add(JMP, 6'h00, E_F1, "j_fetch");   add(JMP, 6'h00, E_DEC, "j_dec");
    add(JMP, 6'h00, E_JMP, "j_jump");
    add(SW, 6'h00, E_F1, "sw_fetch");   add(SW, 6'h00, E_DEC, "sw_dec");
    add(SW, 6'h00, E_MADDR, "sw_addr"); add(SW, 6'h00, E_MWR, "sw_write");
    add(ADDI, 6'h00, E_F1, "addi_fetch"); add(ADDI, 6'h00, E_DEC, "addi_dec");
    add(ADDI, 6'h00, E_AEX, "addi_exe");  add(ADDI, 6'h00, E_AWB, "addi_wb");

    // Reset state
    rst_n = 1'b0; memReady = 1'b1; opcode = LW; functionField = 6'h00; zero = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(obs), 32'd0);
    check("reset_timeout", 32'(memTimeout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven directed instruction sequences, memory always ready
    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].op;
      functionField = tbl[i].fn;
      step(1'b1, tbl[i].exp, tbl[i].nm);
    end

    // Randomised instructions checked against latency and per-signal cycle counts
    for (int n = 0; n < 40; n++) begin
      int kind, f, m, base, t;
      bit is_lw, is_sw, is_r, is_nop, is_beq, is_j, is_addi, is_ill;
      int c_rw, c_mw, c_mr, c_ill, c_pcw, c_pcwc, c_irw;
      logic rd_seen, mtr_seen;
      logic [5:0] op;
      kind = $urandom_range(0, 7);
      is_lw = (kind == 0); is_sw = (kind == 1); is_r = (kind == 2);
      is_nop = (kind == 3); is_beq = (kind == 4); is_j = (kind == 5);
      is_addi = (kind == 6); is_ill = (kind == 7);
      case (kind)
        0: op = LW;   1: op = SW;  2, 3: op = RT;
        4: op = BEQ;  5: op = JMP; 6: op = ADDI;
        default: begin
          op = 6'(($urandom_range(0, 63)));
          while (supported(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      opcode = op;
      functionField = is_nop ? 6'h00 : 6'($urandom_range(1, 63));
      f = $urandom_range(0, 3);
      m = (is_lw || is_sw) ? $urandom_range(0, 3) : 0;
      base = is_lw ? 5 : (is_sw || is_r || is_addi) ? 4 : is_ill ? 2 : 3;
      t = base + f + m;
      c_rw = 0; c_mw = 0; c_mr = 0; c_ill = 0; c_pcw = 0; c_pcwc = 0; c_irw = 0;
      rd_seen = 1'b0; mtr_seen = 1'b0;
      for (int c = 0; c < t; c++) begin
        // Memory access of lw/sw starts three cycles after fetch completes
        memReady = !((c < f) || ((is_lw || is_sw) && c >= f + 3 && c < f + 3 + m));
        zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (c == 0) check("rnd_at_fetch", 32'(MemRead & ~IorD & (AluSrcB == 2'b01)), 32'd1);
        c_rw += RegWrite; c_mw += MemWrite; c_mr += MemRead; c_ill += illegalOp;
        c_pcw += PCWrite; c_pcwc += PCWriteCond; c_irw += IRWrite;
        if (RegWrite) begin rd_seen = RegDst; mtr_seen = MemtoReg; end
        @(posedge clk);
        #1;
      end
      check("rnd_counts",
            {4'(c_rw), 4'(c_mw), 4'(c_mr), 4'(c_ill), 4'(c_pcw), 4'(c_pcwc), 4'(c_irw)},
            {4'((is_lw || is_addi || is_r) ? 1 : 0), 4'(is_sw ? m + 1 : 0),
             4'(f + 1 + (is_lw ? m + 1 : 0)), 4'(is_ill ? 1 : 0),
             4'(is_j ? 2 : 1), 4'(is_beq ? 1 : 0), 4'd1});
      if (is_lw || is_addi || is_r)
        check("rnd_wbsel", {rd_seen, mtr_seen}, {1'(is_r), 1'(is_lw)});
    end

    // sw with three stalled write cycles
    opcode = SW; functionField = 6'h00;
    step(1'b1, E_F1, "sws_fetch");
    step(1'b1, E_DEC, "sws_dec");
    step(1'b1, E_MADDR, "sws_addr");
    for (int i = 0; i < 3; i++) step(1'b0, E_MWR, "sws_stall");
    step(1'b1, E_MWR, "sws_done");

    // Fetch starved for MEM_WAIT_MAX cycles sets the sticky timeout
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, E_F0, "to_fetch_stall");
      check("to_flag", 32'(memTimeout), 32'(i == 15));
    end
    for (int i = 0; i < 3; i++) step(1'b0, E_F0, "to_sticky_fetch");
    step(1'b1, E_F1, "to_fetch_resume");
    check("to_sticky", 32'(memTimeout), 32'd1);

    // Asynchronous reset in the middle of a store
    step(1'b1, E_DEC, "rst_dec");
    step(1'b1, E_MADDR, "rst_addr");
    memReady = 1'b0;
    #2;
    check("rst_in_write", 32'(obs), 32'(E_MWR));
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'(obs), 32'd0);
    check("rst_async_timeout", 32'(memTimeout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    opcode = ADDI;
    step(1'b1, E_F1, "rst_restart_fetch");
    step(1'b1, E_DEC, "rst_restart_dec");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and writeback over several clock cycles. Each cycle it drives the datapath mux selects and write enables, and it drives AluOp into AluControl. It decodes the instruction opcode plus functionField and waits on a memory-ready handshake for every memory access.

Parameters:
MEM_WAIT_MAX, 15, max cycles the FSM waits for memReady in any memory state before raising memTimeout
STATE_W, 4, width of the state register

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instruction bits [31:26], taken from the instruction register
functionField  input  6  instruction bits [5:0], taken from the instruction register
zero  input  1  ALU zero flag
memReady  input  1  memory completed the current read or write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load gated by zero (branch)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination register: 0 = rt, 1 = rd
RegWrite  output  1  register file write enable
AluSrcA  output  1  ALU A: 0 = PC, 1 = register A
AluSrcB  output  2  ALU B: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
AluOp  output  2  to AluControl: 00 = add, 01 = subtract, 10 = use funct
PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
illegalOp  output  1  one-cycle pulse on an unsupported opcode
memTimeout  output  1  sticky flag; cleared only by reset

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = FETCH, wait counter = 0.
  - illegalOp = 0, memTimeout = 0.
  - All control outputs are held at 0 while rst_n is low.
  - A reset in the middle of an instruction aborts it; no pending write is completed.
- Outputs are Moore-decoded from state. Exceptions: PCWrite and IRWrite in FETCH are additionally gated by memReady.
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- States and outputs (signals not listed are 0):
  - FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSource=00; PCWrite=IRWrite=memReady. Stay while memReady=0; go to DECODE when memReady=1.
  - DECODE: AluSrcA=0, AluSrcB=11, AluOp=00. Next state by opcode: lw/sw -> MEM_ADDR, R -> EXECUTE, beq -> BRANCH, j -> JUMP, addi -> ADDI_EX. Any other opcode -> FETCH with illegalOp=1 for that cycle.
  - MEM_ADDR: AluSrcA=1, AluSrcB=10, AluOp=00. lw -> MEM_READ; sw -> MEM_WRITE.
  - MEM_READ: MemRead=1, IorD=1. Stay while memReady=0; then -> MEM_WB.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Then -> FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1. Stay while memReady=0; then -> FETCH.
  - EXECUTE: AluSrcA=1, AluSrcB=00, AluOp=10. If functionField=000000 (nop) -> FETCH and no writeback; otherwise -> R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Then -> FETCH.
  - BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01. Then -> FETCH.
  - JUMP: PCWrite=1, PCSource=10. Then -> FETCH.
  - ADDI_EX: AluSrcA=1, AluSrcB=10, AluOp=00. Then -> ADDI_WB.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Then -> FETCH.
- Latency, assuming memReady=1 on the first memory cycle:
  - lw 5 cycles; sw, R, addi 4; beq, j, nop 3; illegal opcode 2.
  - Each memory wait cycle adds 1.
- Wait counter:
  - Increments on each cycle spent in FETCH, MEM_READ or MEM_WRITE with memReady=0.
  - Clears on every state change.
  - On reaching MEM_WAIT_MAX: memTimeout=1 and the FSM forces the next state to FETCH. The counter saturates and never wraps.
- The unused state encodings go to FETCH on the next clock.

Test Plan:
- Reset and lw: release rst_n, memReady held 1, opcode=100011 -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB over 5 cycles. MEM_WB drives RegWrite=1, MemtoReg=1, RegDst=0. PCWrite=1 only in FETCH.
- R add: opcode=000000, funct=100000 -> EXECUTE drives AluOp=10, AluSrcA=1, AluSrcB=00; R_WB drives RegWrite=1, RegDst=1; back in FETCH at cycle 5.
- nop and illegal opcode: funct=000000 -> FETCH after EXECUTE (3 cycles) with RegWrite never 1. opcode=111111 -> illegalOp pulses for 1 cycle in DECODE, then FETCH.
- beq and jump: beq with zero=1 -> BRANCH drives PCWriteCond=1, AluOp=01, PCSource=01. opcode=000010 -> JUMP drives PCWrite=1, PCSource=10.
- Memory stall and timeout: sw with memReady=0 for 3 cycles, then 1 -> MemWrite held for 4 cycles, then FETCH. memReady=0 for 15 cycles in FETCH -> memTimeout=1 and the FSM stays sticky in FETCH.
- Reset mid-operation: assert rst_n=0 while in MEM_WRITE -> MemWrite drops to 0 immediately (asynchronous); after release the FSM starts in FETCH.
